// File: rtl/bkm_serial_rx.sv
// bkm_serial_rx -- serial word receiver with a first-word-fall-through output FIFO.
//
// The serial clock, data and chip select arrive already filtered and synchronous
// to clk. While chip select is low, words are shifted in MSB first on sck rises.
// Each complete word goes into a small FIFO that the consumer drains with
// rd_valid/rd_ready.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst        synchronous, active-high reset
//   sck_f      filtered serial clock
//   sdi_f      filtered serial data
//   cs_n_f     filtered chip select, active low
//   rd_ready   consumer takes rd_data this cycle
//   rd_data    FIFO head word (zero while empty)
//   rd_valid   FIFO not empty
//   busy       receiver inside a frame (SHIFT)
//   frame_err  one-cycle pulse when a frame ends in the middle of a word
//   overrun    one-cycle pulse when a completed word is dropped on a full FIFO
//   err_cnt    saturating count of frame_err + overrun pulses
//              (present only when BKM_RX_ERRCNT_EN is defined)
//
// Build option: define BKM_RX_ERRCNT_EN to add the err_cnt port and its counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | chip select inactive; sck and sdi are ignored
// SHIFT | inside a frame; sck rises shift bits in, every DATA_W bits a word
//       | is written to the FIFO

module bkm_serial_rx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck_f,
  input  logic              sdi_f,
  input  logic              cs_n_f,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
`ifdef BKM_RX_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic              sck_q, cs_q;
  logic              sck_rise, cs_fall, cs_rise;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shift_reg, shift_nxt;
  logic [DATA_W-1:0] wr_word;
  logic              wr_en;
  logic              ferr_nxt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, push, pop, ovr_nxt;

  // Edge detection on the already-synchronous inputs.
  assign sck_rise = sck_f & ~sck_q;
  assign cs_fall  = ~cs_n_f & cs_q;
  assign cs_rise  = cs_n_f & ~cs_q;

  // The completing bit goes straight into the FIFO word, so the write
  // happens on the same clk edge that samples the final sck rise.
  assign wr_word = {shift_reg[DATA_W-2:0], sdi_f};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      sck_q     <= sck_f;
      cs_q      <= cs_n_f;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    wr_en       = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cs_fall) begin
          state_nxt   = S_SHIFT;
          bit_cnt_nxt = '0;
        end
      end
      S_SHIFT: begin
        // Chip select release wins over a coincident sck rise.
        if (cs_rise) begin
          state_nxt   = S_IDLE;
          bit_cnt_nxt = '0;
          ferr_nxt    = (bit_cnt != '0);
        end else if (cs_fall) begin
          bit_cnt_nxt = '0;
        end else if (sck_rise) begin
          shift_nxt = wr_word;
          if (bit_cnt == LAST_BIT) begin
            wr_en       = 1'b1;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  assign busy = (state == S_SHIFT);

  // FIFO: power-of-two depth so the pointers wrap naturally; occupancy
  // count 0..FIFO_DEPTH distinguishes full from empty.
  assign rd_valid = (count != '0);
  assign full     = (count == FULL_CNT);
  assign pop      = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = wr_en & (~full | pop);
  assign ovr_nxt  = wr_en & full & ~pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_nxt;
      overrun   <= ovr_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef BKM_RX_ERRCNT_EN
  // Counts in step with the pulses, so err_cnt already includes a pulse
  // on the cycle that pulse is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if ((ferr_nxt | ovr_nxt) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bkm_serial_rx.sv
module tb_bkm_serial_rx;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck_f = 1'b0;
  logic       sdi_f = 1'b0;
  logic       cs_n_f = 1'b1;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, busy, frame_err, overrun;
`ifdef BKM_RX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int total = 0;
  int bad = 0;
  int ferr_seen = 0;
  int ovr_seen = 0;

  always #5 clk = ~clk;

  bkm_serial_rx #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .sck_f    (sck_f),
    .sdi_f    (sdi_f),
    .cs_n_f   (cs_n_f),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
`ifdef BKM_RX_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame flag, bit counter, accumulated bits and a queue.
  bit         m_in_frame = 0;
  int         m_bits = 0;
  bit [7:0]   m_acc = 0;
  bit [7:0]   q[$];
  bit         m_ferr = 0, m_ovr = 0;
  bit         m_sck_prev = 0, m_cs_prev = 1;
  int         m_err = 0;
  bit         chk_en = 0;

  always @(posedge clk) begin
    bit rise_sck, fall_cs, rise_cs, take, word_done;
    if (rst) begin
      m_in_frame = 0; m_bits = 0; m_acc = 0; q.delete();
      m_ferr = 0; m_ovr = 0; m_err = 0;
      m_sck_prev = 0; m_cs_prev = 1;
      chk_en = 1;
    end else begin
      rise_sck = sck_f && !m_sck_prev;
      fall_cs  = !cs_n_f && m_cs_prev;
      rise_cs  = cs_n_f && !m_cs_prev;
      take = (q.size() > 0) && rd_ready;
      word_done = 0;
      m_ferr = 0; m_ovr = 0;
      if (!m_in_frame) begin
        if (fall_cs) begin m_in_frame = 1; m_bits = 0; end
      end else if (rise_cs) begin
        m_in_frame = 0;
        m_ferr = (m_bits != 0);
        m_bits = 0;
      end else if (fall_cs) begin
        m_bits = 0;
      end else if (rise_sck) begin
        m_acc = {m_acc[6:0], sdi_f};
        m_bits++;
        if (m_bits == 8) begin word_done = 1; m_bits = 0; end
      end
      if (take) void'(q.pop_front());
      if (word_done) begin
        if (q.size() < DEPTH) q.push_back(m_acc);
        else m_ovr = 1;
      end
      if ((m_ferr || m_ovr) && m_err < 255) m_err++;
      m_sck_prev = sck_f;
      m_cs_prev = cs_n_f;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) chk("rd_data", {24'd0, rd_data}, {24'd0, q[0]});
      else chk("rd_data", {24'd0, rd_data}, 32'd0);
      chk("busy", {31'd0, busy}, {31'd0, m_in_frame});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
`ifdef BKM_RX_ERRCNT_EN
      chk("err_cnt", {24'd0, err_cnt}, m_err);
`endif
      if (frame_err === 1'b1) ferr_seen++;
      if (overrun === 1'b1) ovr_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input bit rdy_on_rise);
    sdi_f = b; sck_f = 1'b0;
    tick();
    sck_f = 1'b1; rd_ready = rdy_on_rise;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit rdy_last);
    for (int i = 7; i >= 0; i--) send_bit(v[i], (i == 0) && rdy_last);
  endtask

  task automatic cs_lo();
    cs_n_f = 1'b0;
    tick();
  endtask

  task automatic cs_hi();
    cs_n_f = 1'b1;
    tick();
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string nm);
    chk({nm, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(nm, {24'd0, rd_data}, {24'd0, exp});
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    int f0, o0;
    logic [7:0] v;
`ifdef BKM_RX_ERRCNT_EN
    logic [7:0] e0;
`endif
    repeat (3) tick();
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_outs", {28'd0, rd_valid, busy, frame_err, overrun}, 32'd0);

    // Single 0xA5 word.
    cs_lo();
    send_byte(8'hA5, 1'b0);
    chk("a5_valid", {31'd0, rd_valid}, 32'd1);
    chk("a5_data", {24'd0, rd_data}, 32'hA5);
    chk("a5_busy", {31'd0, busy}, 32'd1);
    f0 = ferr_seen;
    cs_hi();
    tick();
    chk("a5_idle", {31'd0, busy}, 32'd0);
    chk("a5_no_ferr", ferr_seen - f0, 32'd0);
    pop_expect(8'hA5, "a5_pop");
    chk("a5_empty", {31'd0, rd_valid}, 32'd0);

    // Five words into a four-entry FIFO.
    o0 = ovr_seen;
    cs_lo();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    tick();
    chk("ovr_count", ovr_seen - o0, 32'd1);
    cs_hi();
    for (int i = 1; i <= 4; i++) pop_expect(8'(i), "ovr_drain");
    chk("ovr_empty", {31'd0, rd_valid}, 32'd0);

    // Truncated word after 3 bits; FIFO holds one earlier word.
    cs_lo();
    send_byte(8'h77, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    f0 = ferr_seen;
`ifdef BKM_RX_ERRCNT_EN
    e0 = err_cnt;
`endif
    cs_hi();
    tick();
    chk("trunc_ferr", ferr_seen - f0, 32'd1);
    chk("trunc_idle", {31'd0, busy}, 32'd0);
`ifdef BKM_RX_ERRCNT_EN
    chk("trunc_errcnt", {24'd0, err_cnt}, {24'd0, e0 + 8'd1});
`endif
    pop_expect(8'h77, "trunc_keep");

    // Full FIFO with a simultaneous pop on the final bit of 0x3C.
    o0 = ovr_seen;
    cs_lo();
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b0);
    send_byte(8'h3C, 1'b1);
    tick();
    chk("full_pop_no_ovr", ovr_seen - o0, 32'd0);
    cs_hi();
    pop_expect(8'h11, "full_pop_d1");
    pop_expect(8'h12, "full_pop_d2");
    pop_expect(8'h13, "full_pop_d3");
    pop_expect(8'h3C, "full_pop_tail");

    // cs rise coincident with the 8th sck rise.
    cs_lo();
    v = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
    f0 = ferr_seen;
    sdi_f = v[0]; sck_f = 1'b0;
    tick();
    sck_f = 1'b1; cs_n_f = 1'b1;
    tick();
    tick();
    chk("coinc_ferr", ferr_seen - f0, 32'd1);
    chk("coinc_no_write", {31'd0, rd_valid}, 32'd0);

    // Reset in the middle of a word with one word queued.
    cs_lo();
    send_byte(8'h5A, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    f0 = ferr_seen;
    rst = 1'b1; cs_n_f = 1'b1;
    tick();
    chk("midrst_outs", {28'd0, rd_valid, busy, frame_err, overrun}, 32'd0);
    chk("midrst_data", {24'd0, rd_data}, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("midrst_no_ferr", ferr_seen - f0, 32'd0);
    chk("midrst_empty", {31'd0, rd_valid}, 32'd0);

`ifdef BKM_RX_ERRCNT_EN
    // 300 forced frame errors saturate the counter.
    for (int i = 0; i < 300; i++) begin
      cs_lo();
      send_bit(1'b1, 1'b0);
      cs_hi();
    end
    tick();
    chk("errcnt_sat", {24'd0, err_cnt}, 32'd255);
`endif

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 149) == 0) cs_n_f = ~cs_n_f;
      sck_f = 1'($urandom_range(0, 1));
      sdi_f = 1'($urandom_range(0, 1));
      rd_ready = ($urandom_range(0, 9) < 2);
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0; rd_ready = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
